// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: fetches sequential words from instruction memory into a 2-entry queue for decode.
//
// Ports:
//   clk          - clock; all state changes on the rising edge
//   rst          - asynchronous active-low reset
//   mem_read     - read request to instruction memory
//   address      - word-aligned fetch address; always equals the pc
//   read_data    - instruction word returned in the same cycle as address/mem_read
//   branch_taken - one-cycle redirect request
//   branch_addr  - redirect target
//   instr_valid  - queue head holds an instruction
//   instr_ready  - decode accepts the queue head
//   instr        - queue-head instruction word
//   pc_plus4     - fetch address of the queue head plus 4
//   fetch_fault  - sticky misaligned-redirect flag
//
// Optional feature: define ALIGN_CHECK_EN to trap misaligned redirect targets
// in a sticky FAULT state. Without it, fetch_fault is tied low and the low two
// target bits are dropped.
module instruction_fetch_unit (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_read,
  output logic [31:0] address,
  input  logic [31:0] read_data,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] pc_plus4,
  output logic        fetch_fault
);
`ifdef ALIGN_CHECK_EN
  typedef enum logic [1:0] {BOOT, RUN, REDIRECT, FAULT} state_t;
`else
  typedef enum logic [1:0] {BOOT, RUN, REDIRECT} state_t;
`endif
  state_t      state, state_nxt;
  logic [31:0] pc;
  logic [31:0] q_instr [2];
  logic [31:0] q_pc4 [2];
  logic        hd, tl;
  logic [1:0]  count;
  logic        pop, redirect;
  always_comb begin
    instr_valid = count != 2'd0;
    pop         = instr_valid && instr_ready;
    mem_read    = state == RUN && (count != 2'd2 || pop);
    address     = pc;
    // Head outputs are registered queue contents; gated to zero when empty so reset values hold.
    instr       = instr_valid ? q_instr[hd] : '0;
    pc_plus4    = instr_valid ? q_pc4[hd] : '0;
`ifdef ALIGN_CHECK_EN
    redirect    = branch_taken && state != FAULT;
    fetch_fault = state == FAULT;
`else
    redirect    = branch_taken;
    fetch_fault = 1'b0;
`endif
  end
  always_comb begin
    state_nxt = state;
    if (redirect)
      state_nxt = REDIRECT;
    else if (state == BOOT || state == REDIRECT)
      state_nxt = RUN;
`ifdef ALIGN_CHECK_EN
    if (redirect && branch_addr[1:0] != 2'b00)
      state_nxt = FAULT;
`endif
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= BOOT;
      pc    <= '0;
      count <= '0;
      hd    <= 1'b0;
      tl    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (redirect) begin
        // A redirect wins over any push or pop in the same cycle.
        pc    <= branch_addr & 32'hFFFF_FFFC;
        count <= '0;
        hd    <= 1'b0;
        tl    <= 1'b0;
      end else begin
        if (mem_read) begin
          pc <= pc + 32'd4;
          tl <= ~tl;
        end
        if (pop)
          hd <= ~hd;
        count <= count + {1'b0, mem_read} - {1'b0, pop};
      end
    end
  end
  always_ff @(posedge clk) begin
    if (mem_read && !redirect) begin
      q_instr[tl] <= read_data;
      q_pc4[tl]   <= pc + 32'd4;
    end
  end
endmodule
